// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the shift-add multiplier controller.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mult_state_t;

    function automatic int cnt_w(input int size);
        return $clog2(size);
    endfunction

endpackage

// File: rtl/custom_adder.sv
// Ripple-carry style SIZE-bit adder with carry in/out, shared by the multiplier.
module custom_adder #(
    parameter int SIZE = 32
) (
    input  logic [SIZE-1:0] A,
    input  logic [SIZE-1:0] B,
    input  logic            Cin,
    output logic [SIZE-1:0] Sum,
    output logic            Cout
);

    assign {Cout, Sum} = {1'b0, A} + {1'b0, B} + {{SIZE{1'b0}}, Cin};

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned multiplier: one partial product per cycle through a single adder,
// fixed SIZE-cycle latency, result held on Product until the next load.
module shift_add_mult_ctrl
    import mult_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [SIZE-1:0]   A,
    input  logic [SIZE-1:0]   B,
    output logic              busy,
    output logic              done,
    output logic [2*SIZE-1:0] Product
);

    localparam int CNT_W = cnt_w(SIZE);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SIZE - 1);

    mult_state_t      state, state_nxt;
    logic [SIZE-1:0]  mcand;
    logic [SIZE-1:0]  acc_hi;
    logic [SIZE-1:0]  acc_lo;
    logic [CNT_W-1:0] cnt;

    logic [SIZE-1:0]   add_b;
    logic [SIZE-1:0]   sum;
    logic              cout;
    logic [2*SIZE-1:0] shifted;

    assign add_b = acc_lo[0] ? mcand : '0;

    custom_adder #(.SIZE(SIZE)) u_add (
        .A    (acc_hi),
        .B    (add_b),
        .Cin  (1'b0),
        .Sum  (sum),
        .Cout (cout)
    );

    // The carry-out becomes the top product bit, so the 2*SIZE+1 value shifts right by one.
    assign shifted = {cout, sum, acc_lo[SIZE-1:1]};

    assign busy = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            cnt     <= '0;
            Product <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= A;
                        acc_hi <= '0;
                        acc_lo <= B;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    acc_hi <= shifted[2*SIZE-1:SIZE];
                    acc_lo <= shifted[SIZE-1:0];
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        Product <= shifted;
                        done    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Scoreboard bench for shift_add_mult_ctrl at SIZE=32.
module tb_shift_add_mult_ctrl;

    localparam int SIZE = 32;
    localparam int LAT  = SIZE + 1;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [SIZE-1:0]   A;
    logic [SIZE-1:0]   B;
    logic              busy;
    logic              done;
    logic [2*SIZE-1:0] Product;

    logic [2*SIZE-1:0] sb[$];
    int checks   = 0;
    int failures = 0;

    shift_add_mult_ctrl #(.SIZE(SIZE)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .Product (Product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*SIZE-1:0] mul(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
        logic [2*SIZE-1:0] x;
        logic [2*SIZE-1:0] y;
        x = {{SIZE{1'b0}}, a};
        y = {{SIZE{1'b0}}, b};
        return x * y;
    endfunction

    // Counts negedges until done is seen (bounded); records whether busy stayed high.
    task automatic wait_done(output int n, output logic busy_ok);
        n = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            n++;
            if (!busy) busy_ok = 1'b0;
        end while (!done && n < 3 * LAT);
    endtask

    task automatic run_one(input string name, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
        int n;
        logic bok;
        logic [2*SIZE-1:0] exp;
        @(negedge clk);
        A = a;
        B = b;
        start = 1'b1;
        sb.push_back(mul(a, b));
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(n, bok);
        exp = sb.pop_front();
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s timeout: done not seen within %0d cycles", name, n);
        end
        checks++;
        if (n !== LAT) begin
            failures++;
            $display("FAIL %s latency: got %0d cycles, expected %0d", name, n, LAT);
        end
        checks++;
        if (bok !== 1'b1) begin
            failures++;
            $display("FAIL %s busy: dropped before done", name);
        end
        checks++;
        if (Product !== exp) begin
            failures++;
            $display("FAIL %s product: got %h, expected %h", name, Product, exp);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || Product !== exp) begin
            failures++;
            $display("FAIL %s after_done: done=%b busy=%b Product=%h, expected 0 0 %h",
                     name, done, busy, Product, exp);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || Product !== '0) begin
            failures++;
            $display("FAIL reset_state: busy=%b done=%b Product=%h, expected 0 0 0", busy, done, Product);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_start: busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_basic;
        run_one("mul_3x5", 32'd3, 32'd5);
    endtask

    task automatic test_corners;
        run_one("mul_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checks++;
        if (Product !== 64'hFFFF_FFFE_0000_0001) begin
            failures++;
            $display("FAIL max_const: got %h, expected fffffffe00000001", Product);
        end
        run_one("mul_b_zero", 32'h1234_5678, 32'h0);
        run_one("mul_a_zero", 32'h0, 32'hDEAD_BEEF);
    endtask

    task automatic test_held_start;
        int n;
        logic bok;
        logic [2*SIZE-1:0] exp;
        @(negedge clk);
        A = 32'd1000;
        B = 32'd77;
        start = 1'b1;
        sb.push_back(mul(32'd1000, 32'd77));
        repeat (10) @(negedge clk);
        A = 32'hABCD_0123;
        B = 32'h0000_F00D;
        sb.push_back(mul(32'hABCD_0123, 32'h0000_F00D));
        wait_done(n, bok);
        exp = sb.pop_front();
        checks++;
        if (!done || Product !== exp) begin
            failures++;
            $display("FAIL held_first: done=%b Product=%h, expected 1 %h", done, Product, exp);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || Product !== exp) begin
            failures++;
            $display("FAIL held_idle_gap: busy=%b done=%b Product=%h, expected 0 0 %h",
                     busy, done, Product, exp);
        end
        @(posedge clk);
        #1 start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL held_reaccept: busy=%b, expected 1", busy);
        end
        wait_done(n, bok);
        exp = sb.pop_front();
        checks++;
        if (!done || n !== LAT || Product !== exp) begin
            failures++;
            $display("FAIL held_second: done=%b cycles=%0d Product=%h, expected 1 %0d %h",
                     done, n, Product, LAT, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic seen_done;
        @(negedge clk);
        A = 32'h0F0F_0F0F;
        B = 32'h1357_9BDF;
        start = 1'b1;
        sb.push_back(mul(32'h0F0F_0F0F, 32'h1357_9BDF));
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        void'(sb.pop_back());
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || Product !== '0) begin
            failures++;
            $display("FAIL reset_mid_async: busy=%b done=%b Product=%h, expected 0 0 0", busy, done, Product);
        end
        seen_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        rst_n = 1'b1;
        repeat (LAT + 3) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_no_done: activity after reset, expected none");
        end
        run_one("mul_7x9", 32'd7, 32'd9);
        checks++;
        if (Product !== 64'd63) begin
            failures++;
            $display("FAIL mul_7x9_const: got %0d, expected 63", Product);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        logic bok;
        logic [SIZE-1:0] a;
        logic [SIZE-1:0] b;
        logic [2*SIZE-1:0] exp;
        @(negedge clk);
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 50 == 0) a = '1;
            if (i % 70 == 1) b = '0;
            A = a;
            B = b;
            start = 1'b1;
            sb.push_back(mul(a, b));
            @(posedge clk);
            #1;
            wait_done(n, bok);
            exp = sb.pop_front();
            checks++;
            if (!done || n !== LAT || !bok || Product !== exp) begin
                failures++;
                $display("FAIL b2b[%0d]: done=%b cycles=%0d busy_ok=%b Product=%h, expected 1 %0d 1 %h",
                         i, done, n, bok, Product, LAT, exp);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL b2b_width[%0d]: done=%b busy=%b, expected 0 0", i, done, busy);
            end
        end
        start = 1'b0;
        checks++;
        if (sb.size() !== 0) begin
            failures++;
            $display("FAIL scoreboard_empty: %0d left, expected 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_held_start();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
